// File: rtl/change_stim_gen_pkg.sv
// Shared types and constants for the idx/data stimulus generator.
// Holds the sequence-mode and FSM encodings plus the LFSR step function.
package change_stim_pkg;

    typedef enum logic [1:0] {
        MODE_WALK   = 2'd0,
        MODE_LFSR   = 2'd1,
        MODE_SWEEP  = 2'd2,
        MODE_TOGGLE = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [14:0] WALK_INIT     = 15'h0001;
    localparam logic [14:0] SWEEP_PATTERN = 15'h2AAA;
    localparam logic [14:0] TOGGLE_MASK   = 15'h0008;
    localparam logic [3:0]  TOGGLE_IDX    = 4'd3;

    // Fibonacci LFSR, polynomial x^15 + x^14 + 1.
    function automatic logic [14:0] lfsr15_next(input logic [14:0] cur);
        return {cur[13:0], cur[14] ^ cur[13]};
    endfunction

endpackage

// File: rtl/change_stim_gen_if.sv
// idx/data stimulus bus: start/mode request in, status and driven values out.
// The generator is the master; monitors and the requester sit on the slave side.
interface change_stim_gen_if;

    logic        start;
    logic [1:0]  mode;
    logic        busy;
    logic        done;
    logic        upd;
    logic [5:0]  step;
    logic [3:0]  idx;
    logic [14:0] data;

    modport master (
        input  start,
        input  mode,
        output busy,
        output done,
        output upd,
        output step,
        output idx,
        output data
    );

    modport slave (
        output start,
        output mode,
        input  busy,
        input  done,
        input  upd,
        input  step,
        input  idx,
        input  data
    );

endinterface

// File: rtl/change_stim_gen_hold_timer.sv
// Update cadence timer: a load restarts a HOLD-cycle window, tick marks its last cycle.
// Latency: tick is high in the cycle before the edge HOLD cycles after the load; no backpressure.
module stim_hold_timer #(
    parameter int HOLD = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic tick_o
);

    localparam logic [3:0] RELOAD = 4'(HOLD - 1);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = RELOAD;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Reaching zero means the next edge is exactly HOLD cycles after the load.
    assign tick_o = en_i && (cnt_q == 4'd0);

endmodule

// File: rtl/change_stim_gen.sv
// Scripted idx/data stimulus generator: one sequence of NUM_STEPS updates, HOLD cycles apart, per start.
// Latency: first update on the start edge, done NUM_STEPS*HOLD edges later; start ignored unless idle.
module change_stim_gen
    import change_stim_pkg::*;
#(
    parameter int          HOLD      = 3,
    parameter int          NUM_STEPS = 8,
    parameter logic [14:0] SEED      = 15'h0001
) (
    input  logic              clk,
    input  logic              rst,
    change_stim_gen_if.master bus
);

    localparam logic [14:0] SEED_EFF  = (SEED == 15'h0000) ? 15'h0001 : SEED;
    localparam logic [5:0]  LAST_STEP = 6'(NUM_STEPS);

    state_e      state_q, state_d;
    mode_e       mode_q, mode_d;
    logic [3:0]  idx_q, idx_d;
    logic [14:0] data_q, data_d;
    logic [5:0]  step_q, step_d;
    logic        upd_q, upd_d;
    logic        timer_load;
    logic        timer_tick;
    logic        running;
    logic [14:0] lfsr_nxt;
    mode_e       start_mode;

    assign running    = (state_q == RUN);
    assign lfsr_nxt   = lfsr15_next(data_q);
    assign start_mode = mode_e'(bus.mode);

    stim_hold_timer #(
        .HOLD (HOLD)
    ) u_hold_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (timer_load),
        .en_i   (running),
        .tick_o (timer_tick)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        idx_d      = idx_q;
        data_d     = data_q;
        step_d     = step_q;
        upd_d      = 1'b0;
        timer_load = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = RUN;
                    mode_d     = start_mode;
                    step_d     = 6'd1;
                    upd_d      = 1'b1;
                    timer_load = 1'b1;
                    case (start_mode)
                        MODE_WALK: begin
                            data_d = WALK_INIT;
                            idx_d  = 4'd0;
                        end
                        MODE_LFSR: begin
                            data_d = SEED_EFF;
                            idx_d  = SEED_EFF[3:0];
                        end
                        MODE_SWEEP: begin
                            data_d = SWEEP_PATTERN;
                            idx_d  = 4'd0;
                        end
                        default: begin
                            data_d = 15'h0000;
                            idx_d  = TOGGLE_IDX;
                        end
                    endcase
                end
            end

            RUN: begin
                if (timer_tick) begin
                    // The final update still owns a full HOLD window before DONE.
                    if (step_q == LAST_STEP) begin
                        state_d = DONE;
                    end else begin
                        step_d     = step_q + 6'd1;
                        upd_d      = 1'b1;
                        timer_load = 1'b1;
                        case (mode_q)
                            MODE_WALK: begin
                                data_d = {data_q[13:0], data_q[14]};
                            end
                            MODE_LFSR: begin
                                data_d = lfsr_nxt;
                                idx_d  = lfsr_nxt[3:0];
                            end
                            MODE_SWEEP: begin
                                idx_d = idx_q + 4'd1;
                            end
                            default: begin
                                data_d = data_q ^ TOGGLE_MASK;
                            end
                        endcase
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_WALK;
            idx_q   <= 4'd0;
            data_q  <= 15'h0000;
            step_q  <= 6'd0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            step_q  <= step_d;
            upd_q   <= upd_d;
        end
    end

    assign bus.busy = running;
    assign bus.done = (state_q == DONE);
    assign bus.upd  = upd_q;
    assign bus.step = step_q;
    assign bus.idx  = idx_q;
    assign bus.data = data_q;

endmodule

// File: tb/tb_change_stim_gen.sv
// Scoreboard bench: several generator configurations, randomized sequences checked against a reference model.
module tb_change_stim_gen;
    import change_stim_pkg::*;

    localparam int NI     = 5;
    localparam int K_UPD  = 0;
    localparam int K_DONE = 1;
    localparam int K_SNAP = 2;

    function automatic int hold_of(input int g);
        case (g)
            0:       return 3;
            1:       return 1;
            2:       return 1;
            3:       return 2;
            default: return 15;
        endcase
    endfunction

    function automatic int nsteps_of(input int g);
        case (g)
            0:       return 4;
            1:       return 16;
            2:       return 3;
            3:       return 18;
            default: return 1;
        endcase
    endfunction

    function automatic logic [14:0] seed_of(input int g);
        case (g)
            0:       return 15'h0001;
            1:       return 15'h0000;
            2:       return 15'h6000;
            3:       return 15'h1234;
            default: return 15'h7FFF;
        endcase
    endfunction

    typedef struct {
        int          cyc;
        int          kind;
        logic [3:0]  idx;
        logic [14:0] data;
        logic [5:0]  step;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a   [NI];
    logic        start_a [NI];
    logic [1:0]  mode_a  [NI];
    logic        busy_a  [NI];
    logic        done_a  [NI];
    logic        upd_a   [NI];
    logic [5:0]  step_a  [NI];
    logic [3:0]  idx_a   [NI];
    logic [14:0] data_a  [NI];

    exp_t exp_q [NI][$];
    int   bf    [NI];
    int   bu    [NI];
    int   ecnt     = 0;
    int   checks   = 0;
    int   failures = 0;
    bit   fin      = 1'b0;
    bit   fin_done = 1'b0;

    genvar g;
    for (g = 0; g < NI; g++) begin : gi
        change_stim_gen_if bus ();

        assign bus.start = start_a[g];
        assign bus.mode  = mode_a[g];
        assign busy_a[g] = bus.busy;
        assign done_a[g] = bus.done;
        assign upd_a[g]  = bus.upd;
        assign step_a[g] = bus.step;
        assign idx_a[g]  = bus.idx;
        assign data_a[g] = bus.data;

        change_stim_gen #(
            .HOLD      (hold_of(g)),
            .NUM_STEPS (nsteps_of(g)),
            .SEED      (seed_of(g))
        ) dut (
            .clk (clk),
            .rst (rst_a[g]),
            .bus (bus)
        );
    end

    initial begin
        forever begin
            @(posedge clk);
            ecnt = ecnt + 1;
        end
    end

    task automatic chk(input string name, input int i, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s inst=%0d edge=%0d got=%0h want=%0h", name, i, ecnt, act, exp);
        end
    endtask

    // Reference sequence computed from the mode rules, indexed by update number.
    task automatic push_seq(input int i, input int m, input int e);
        int   h;
        int   n;
        int   v;
        int   x;
        exp_t t;
        h = hold_of(i);
        n = nsteps_of(i);
        v = 0;
        x = 0;
        for (int j = 0; j < n; j++) begin
            case (m)
                0: begin
                    v = 1 << (j % 15);
                    x = 0;
                end
                1: begin
                    if (j == 0) v = (seed_of(i) == 15'd0) ? 1 : int'(seed_of(i));
                    else        v = ((v << 1) & 32'h7FFF) | (((v >> 14) ^ (v >> 13)) & 1);
                    x = v % 16;
                end
                2: begin
                    v = 32'h2AAA;
                    x = j % 16;
                end
                default: begin
                    v = (j % 2 == 1) ? 8 : 0;
                    x = 3;
                end
            endcase
            t.cyc  = e + j * h;
            t.kind = K_UPD;
            t.idx  = 4'(x);
            t.data = 15'(v);
            t.step = 6'(j + 1);
            exp_q[i].push_back(t);
        end
        t.cyc  = e + n * h;
        t.kind = K_DONE;
        exp_q[i].push_back(t);
        bf[i] = e;
        bu[i] = e + n * h;
    endtask

    task automatic push_snap(input int i, input int c);
        exp_t t;
        t.cyc  = c;
        t.kind = K_SNAP;
        t.idx  = 4'd0;
        t.data = 15'd0;
        t.step = 6'd0;
        exp_q[i].push_back(t);
    endtask

    task automatic flush_from(input int i, input int r);
        while (exp_q[i].size() > 0 && exp_q[i][exp_q[i].size() - 1].cyc >= r) begin
            void'(exp_q[i].pop_back());
        end
        if (bu[i] > r) bu[i] = r;
    endtask

    task automatic run_seq(input int i, input int m, input bit glitch, input bit chain);
        int h;
        int n;
        int e;
        int pw;
        h = hold_of(i);
        n = nsteps_of(i);
        @(negedge clk);
        start_a[i] = 1'b1;
        mode_a[i]  = 2'(m);
        e = ecnt + 1;
        push_seq(i, m, e);
        pw = $urandom_range(0, n * h - 1);
        for (int w = 0; w < n * h; w++) begin
            @(negedge clk);
            start_a[i] = chain || (glitch && w == pw);
            mode_a[i]  = 2'($urandom_range(0, 3));
        end
        @(negedge clk);
        start_a[i] = chain;
    endtask

    task automatic reset_test();
        int e;
        int h;
        h = hold_of(0);
        @(negedge clk);
        start_a[0] = 1'b1;
        mode_a[0]  = 2'(MODE_TOGGLE);
        e = ecnt + 1;
        push_seq(0, 3, e);
        @(negedge clk);
        start_a[0] = 1'b0;
        repeat (h) @(negedge clk);
        start_a[0] = 1'b1;
        @(negedge clk);
        start_a[0] = 1'b0;
        repeat (h - 1) @(negedge clk);
        rst_a[0] = 1'b1;
        flush_from(0, ecnt + 1);
        push_snap(0, ecnt + 1);
        @(negedge clk);
        rst_a[0]   = 1'b0;
        @(negedge clk);
        rst_a[0]   = 1'b1;
        start_a[0] = 1'b1;
        mode_a[0]  = 2'($urandom_range(0, 3));
        push_snap(0, ecnt + 1);
        @(negedge clk);
        rst_a[0]   = 1'b0;
        start_a[0] = 1'b0;
        push_snap(0, ecnt + 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        exp_t t;
        bit   seen_u;
        bit   seen_d;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                seen_u = 1'b0;
                seen_d = 1'b0;
                while (exp_q[i].size() > 0 && exp_q[i][0].cyc <= ecnt) begin
                    t = exp_q[i].pop_front();
                    if (t.cyc < ecnt) begin
                        chk("event_edge", i, ecnt, t.cyc);
                    end else begin
                        chk("step", i, int'(step_a[i]), int'(t.step));
                        chk("idx",  i, int'(idx_a[i]),  int'(t.idx));
                        chk("data", i, int'(data_a[i]), int'(t.data));
                        case (t.kind)
                            K_UPD: begin
                                chk("upd_pulse", i, int'(upd_a[i]), 1);
                                seen_u = 1'b1;
                            end
                            K_DONE: begin
                                chk("done_pulse", i, int'(done_a[i]), 1);
                                seen_d = 1'b1;
                            end
                            default: begin
                                chk("idle_upd",  i, int'(upd_a[i]),  0);
                                chk("idle_done", i, int'(done_a[i]), 0);
                            end
                        endcase
                    end
                end
                if (ecnt >= 1) begin
                    chk("busy", i, int'(busy_a[i]), (ecnt >= bf[i] && ecnt < bu[i]) ? 1 : 0);
                    if (upd_a[i] && !seen_u)  chk("spurious_upd",  i, int'(upd_a[i]),  int'(seen_u));
                    if (done_a[i] && !seen_d) chk("spurious_done", i, int'(done_a[i]), int'(seen_d));
                end
                if (fin && !fin_done) chk("queue_drained", i, exp_q[i].size(), 0);
            end
            if (fin) fin_done = 1'b1;
        end
    end

    initial begin
        int  i;
        int  m;
        bit  gl;
        for (int k = 0; k < NI; k++) begin
            rst_a[k]   = 1'b1;
            start_a[k] = 1'b0;
            mode_a[k]  = 2'd0;
            bf[k]      = 0;
            bu[k]      = 0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            rst_a[k] = 1'b0;
            push_snap(k, ecnt + 1);
        end
        repeat (2) @(negedge clk);

        run_seq(0, MODE_WALK,  1'b0, 1'b0);
        run_seq(1, MODE_WALK,  1'b0, 1'b0);
        run_seq(1, MODE_LFSR,  1'b0, 1'b0);
        run_seq(2, MODE_LFSR,  1'b0, 1'b0);
        run_seq(3, MODE_SWEEP, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) run_seq(4, k, 1'b0, k < 3);
        reset_test();

        for (int r = 0; r < 20; r++) begin
            i  = $urandom_range(0, NI - 1);
            m  = $urandom_range(0, 3);
            gl = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                run_seq(i, m, gl, 1'b1);
                run_seq(i, $urandom_range(0, 3), 1'b0, 1'b0);
            end else begin
                run_seq(i, m, gl, 1'b0);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        fin = 1'b1;
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/change_stim_gen.md
Name: change_stim_gen

Overview:
- Clocked stimulus generator that drives an index/data pair, idx[3:0] and data[14:0], into sensitivity-list monitor blocks.
- Produces scripted value sequences at a fixed cadence, so that the monitors' always-triggered $display output is deterministic.
- It is the driving end of the idx/data interface; the monitors are the observing end.
- Runs one sequence per start request and signals completion with a done pulse.

Parameters:
- HOLD, 3: cycles between successive updates; legal range 1..15.
- NUM_STEPS, 8: updates per sequence, including the initial load; legal range 1..63.
- SEED, 15'h0001: initial LFSR value. Zero is forced to 15'h0001.

Ports:
- clk  input  1  sole clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a sequence; accepted only in IDLE.
- mode  input  2  sequence select, sampled only on an accepted start. 0 = walk-one, 1 = LFSR, 2 = idx sweep, 3 = bit-3 toggle.
- busy  output  1  high while a sequence is running.
- done  output  1  one-cycle pulse at the end of a sequence.
- upd  output  1  one-cycle pulse in each cycle where idx/data took a new value.
- step  output  6  count of updates issued in the current or last sequence.
- idx  output  4  driven index.
- data  output  15  driven data.

Behaviour:
- Reset (rst high at an edge): state = IDLE. idx = 0, data = 0, busy = 0, done = 0, upd = 0, step = 0, hold count = 0.
- rst overrides start and every other event in the same cycle, including mid-sequence; no partial update is emitted.
- States: IDLE, RUN, DONE.
- IDLE:
  - Outputs hold their last values; upd = 0, done = 0.
  - start = 1 at edge N: after edge N, state = RUN, busy = 1, upd = 1, step = 1, the initial value is loaded, and the latched mode is captured.
- Initial values per mode:
  - walk-one: data = 15'h0001, idx = 0.
  - LFSR: data = SEED (15'h0001 if SEED is zero), idx = data[3:0].
  - sweep: data = 15'h2AAA, idx = 0.
  - toggle: data = 15'h0000, idx = 3.
- RUN:
  - A hold counter counts HOLD cycles per update, so updates land on edges N, N+HOLD, N+2·HOLD, and so on.
  - Each update increments step and pulses upd for exactly one cycle. Between updates, idx and data are stable and upd = 0.
- Update rules:
  - walk-one: data rotates left within 15 bits; bit 14 wraps to bit 0. idx is unchanged.
  - LFSR: data = {data[13:0], data[14]^data[13]}, i.e. x^15+x^14+1. idx = low 4 bits of the new data. idx = 15 is legal and deliberately out of range for the monitors.
  - sweep: data is unchanged; idx = idx+1 modulo 16 (15 wraps to 0).
  - toggle: data = data ^ 15'h0008; idx stays 3.
- Completion:
  - After the update with step == NUM_STEPS, the block holds for HOLD cycles, then enters DONE at edge N + NUM_STEPS·HOLD.
  - In DONE: done = 1 and busy = 0 for one cycle, then the block returns to IDLE.
  - busy is therefore high for exactly NUM_STEPS·HOLD cycles.
  - idx, data and step keep their last values after completion.
- start while in RUN or DONE is ignored; no queueing. A start held high through DONE is accepted on the first IDLE cycle.
- NUM_STEPS = 1: a single update (upd pulse), then DONE HOLD cycles later.
- A mode change during RUN has no effect.

Decomposition:
- Package change_stim_pkg holds:
  - the mode enum (MODE_WALK, MODE_LFSR, MODE_SWEEP, MODE_TOGGLE);
  - the state enum (IDLE, RUN, DONE);
  - the constants WALK_INIT = 15'h0001, SWEEP_PATTERN = 15'h2AAA, TOGGLE_MASK = 15'h0008, TOGGLE_IDX = 4'd3;
  - the function lfsr15_next.
- One sub-module, stim_hold_timer:
  - loadable down-counter of width 4;
  - load strobe in, tick out one cycle before expiry, aligned so that updates land every HOLD cycles;
  - synchronous active-high rst.

Test Plan:
- Walk-one, HOLD=3, NUM_STEPS=4, start at cycle 0:
  - data = 0001, 0002, 0004, 0008 after edges 0, 3, 6, 9;
  - upd pulses on those cycles only;
  - done = 1 after edge 12; busy high for 12 cycles; step = 4.
- Walk wrap, HOLD=1, NUM_STEPS=16: step 15 gives data = 4000, step 16 gives data = 0001.
- LFSR, SEED = 15'h6000, HOLD=1, NUM_STEPS=3:
  - data = 6000, 4000, 0001;
  - idx = 0, 0, 1.
- LFSR, SEED = 0: first data = 0001.
- Sweep, HOLD=2, NUM_STEPS=18:
  - idx = 0..15, then 0, 1;
  - data constant 2AAA throughout.
- Toggle mode with disruptions:
  - start pulsed again at step 2: ignored, and step continues normally.
  - rst asserted at step 3: after that edge all outputs are 0 and the state is IDLE.
  - start and rst in the same cycle: stays in IDLE with busy = 0.
